// File: rtl/memory_access_unit_if.sv
// Bundle of the load/store request/response handshake and the data-memory
// bus seen by memory_access_unit. The unit itself connects through the
// slave modport. The CPU side, which also models the memory, uses master.
interface memory_access_unit_if;

  // Request from the CPU datapath
  logic        reqValid;
  logic        reqReady;
  logic        reqWrite;
  logic [1:0]  reqSize;
  logic        reqSigned;
  logic [63:0] reqAddress;
  logic [63:0] reqWriteData;

  // Completion back to the CPU datapath
  logic        respValid;
  logic [63:0] respData;
  logic        respError;
  logic        busy;

  // Data-memory bus
  logic        memWrite;
  logic        memRead;
  logic [1:0]  sizeSelect;
  logic [63:0] address;
  logic [63:0] writeData;
  logic [63:0] readData;

  modport master (
    output reqValid, reqWrite, reqSize, reqSigned, reqAddress, reqWriteData,
    output readData,
    input  reqReady, respValid, respData, respError, busy,
    input  memWrite, memRead, sizeSelect, address, writeData
  );

  modport slave (
    input  reqValid, reqWrite, reqSize, reqSigned, reqAddress, reqWriteData,
    input  readData,
    output reqReady, respValid, respData, respError, busy,
    output memWrite, memRead, sizeSelect, address, writeData
  );

endinterface

// File: rtl/memory_access_unit.sv
// Load/store sequencer between the CPU datapath and a byte-addressed data
// memory. It takes one request at a time and rejects misaligned or
// out-of-range accesses without touching the memory. A good access gets one
// setup cycle, then ACCESS_CYCLES strobe cycles, then a one-cycle response.
// Loads are returned sign- or zero-extended.
module memory_access_unit #(
  parameter int unsigned ACCESS_CYCLES = 1,    // strobe length, 1..15 (0 acts as 1)
  parameter int unsigned MEM_BYTES     = 720,  // memory size in bytes
  parameter bit          CHECK_ALIGN   = 1'b1  // enable natural-alignment check
) (
  input logic                 clk,
  input logic                 reset,
  memory_access_unit_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2,
    RESP   = 2'd3
  } state_e;

  localparam logic [1:0] SIZE_WORD   = 2'b00;
  localparam logic [1:0] SIZE_HALF   = 2'b01;
  localparam logic [1:0] SIZE_BYTE   = 2'b10;
  localparam logic [1:0] SIZE_DOUBLE = 2'b11;

  // The counter value on the last strobe cycle is 0, so it is loaded with
  // ACCESS_CYCLES-1. A zero length is folded onto a single cycle.
  localparam logic [3:0]  STROBE_LAST = (ACCESS_CYCLES == 0) ? 4'd0
                                                             : 4'(ACCESS_CYCLES - 1);
  // Bounds are compared in 65 bits so that an address which wraps past 2^64
  // still counts as out of range.
  localparam logic [64:0] MEM_LIMIT   = 65'(MEM_BYTES);

  // Architectural state
  state_e      state_q,     state_d;
  logic [3:0]  cnt_q,       cnt_d;
  logic [63:0] addr_q,      addr_d;
  logic [1:0]  size_q,      size_d;
  logic [63:0] wdata_q,     wdata_d;
  logic        write_q,     write_d;
  logic        signed_q,    signed_d;
  logic [63:0] resp_data_q, resp_data_d;
  logic        resp_err_q,  resp_err_d;

  // Request qualification, evaluated on the live request fields
  logic [3:0]  req_nbytes;
  logic [64:0] req_end;
  logic        req_misaligned;
  logic        req_oob;
  logic        req_error;

  // Narrow load data is widened from its top bit (signed) or with zeros.
  function automatic logic [63:0] extend_load(input logic [1:0]  size,
                                              input logic        sgn,
                                              input logic [63:0] raw);
    logic [63:0] result;
    result = raw;
    case (size)
      SIZE_BYTE: result = {{56{sgn & raw[7]}},  raw[7:0]};
      SIZE_HALF: result = {{48{sgn & raw[15]}}, raw[15:0]};
      SIZE_WORD: result = {{32{sgn & raw[31]}}, raw[31:0]};
      default:   result = raw;
    endcase
    return result;
  endfunction

  // Decode access width and flag misalignment or out-of-range requests
  always_comb begin
    // NOTE: every variable gets a value before any branch, so no path can leave
    // one unassigned and infer a latch.
    req_nbytes     = 4'd8;
    req_misaligned = 1'b0;
    case (bus.reqSize)
      SIZE_WORD: begin
        req_nbytes     = 4'd4;
        req_misaligned = |bus.reqAddress[1:0];
      end
      SIZE_HALF: begin
        req_nbytes     = 4'd2;
        req_misaligned = bus.reqAddress[0];
      end
      SIZE_BYTE: begin
        req_nbytes     = 4'd1;
        req_misaligned = 1'b0;
      end
      default: begin
        req_nbytes     = 4'd8;
        req_misaligned = |bus.reqAddress[2:0];
      end
    endcase
    req_end   = {1'b0, bus.reqAddress} + 65'(req_nbytes);
    req_oob   = (req_end > MEM_LIMIT);
    req_error = (CHECK_ALIGN && req_misaligned) || req_oob;
  end

  // Next-state and datapath-register updates for the access sequence
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    size_d      = size_q;
    wdata_d     = wdata_q;
    write_d     = write_q;
    signed_d    = signed_q;
    resp_data_d = resp_data_q;
    resp_err_d  = resp_err_q;

    unique case (state_q)
      IDLE: begin
        if (bus.reqValid) begin
          write_d  = bus.reqWrite;
          signed_d = bus.reqSigned;
          if (req_error) begin
            // Rejected: the memory bus keeps its previous contents and the
            // response goes out on the very next cycle.
            state_d     = RESP;
            resp_err_d  = 1'b1;
            resp_data_d = '0;
          end else begin
            state_d = SETUP;
            addr_d  = bus.reqAddress;
            size_d  = bus.reqSize;
            if (bus.reqWrite) begin
              wdata_d = bus.reqWriteData;
            end
          end
        end
      end

      SETUP: begin
        state_d = STROBE;
        cnt_d   = STROBE_LAST;
      end

      STROBE: begin
        if (cnt_q == 4'd0) begin
          state_d     = RESP;
          resp_err_d  = 1'b0;
          resp_data_d = write_q ? 64'd0 : extend_load(size_q, signed_q, bus.readData);
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      RESP: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with asynchronous clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      addr_q      <= '0;
      size_q      <= 2'b00;
      wdata_q     <= '0;
      write_q     <= 1'b0;
      signed_q    <= 1'b0;
      resp_data_q <= '0;
      resp_err_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking updates let every register see the pre-edge value
      // of every other, matching real flip-flop behaviour.
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      size_q      <= size_d;
      wdata_q     <= wdata_d;
      write_q     <= write_d;
      signed_q    <= signed_d;
      resp_data_q <= resp_data_d;
      resp_err_q  <= resp_err_d;
    end
  end

  // The strobes are decoded straight from the state register. Reset clears
  // the state asynchronously, so they drop without waiting for a clock edge.
  // Only one strobe can be active because write_q picks exactly one of them.
  assign bus.memWrite   = (state_q == STROBE) &&  write_q;
  assign bus.memRead    = (state_q == STROBE) && !write_q;
  assign bus.address    = addr_q;
  assign bus.sizeSelect = size_q;
  assign bus.writeData  = wdata_q;

  assign bus.reqReady   = (state_q == IDLE);
  assign bus.busy       = (state_q != IDLE);
  assign bus.respValid  = (state_q == RESP);
  assign bus.respData   = resp_data_q;
  assign bus.respError  = resp_err_q;

endmodule
